// File: rtl/pdt_pkg.sv
// Shared types and sizing helpers for the parallel data transfer receive path.
package pdt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/parallel_data_receiver_if.sv
// Transmitter req/ack handshake plus the consumer-side FWFT valid/ready port.
interface parallel_data_receiver_if
    import pdt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = ptr_width(DEPTH) + 1
);
    logic             req;
    logic [WIDTH-1:0] data_in;
    logic             ack;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             full;

    // master: the transmitter and consumer driving the receiver
    modport master (
        output req, data_in, out_ready,
        input  ack, data_out, out_valid, count, full
    );

    modport slave (
        input  req, data_in, out_ready,
        output ack, data_out, out_valid, count, full
    );

endinterface

// File: rtl/pdt_fifo.sv
// Synchronous first-word-fall-through FIFO, zero output when empty.
// Latency: written word visible one cycle after push; push ignored when full, pop ignored when empty.
module pdt_fifo
    import pdt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = ptr_width(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/parallel_data_receiver.sv
// Four-phase req/ack receiver buffering words into a FWFT FIFO for a valid/ready consumer.
// Latency: one cycle capture-to-output; transmitter stalls (no ack) while the FIFO is full.
module parallel_data_receiver
    import pdt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    parallel_data_receiver_if.slave   bus
);

    localparam int CNT_W = ptr_width(DEPTH) + 1;

    state_e           state_q;
    logic             ack_q;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [WIDTH-1:0] fifo_dout;

    // Registered full gates the push, so a same-cycle pop never frees a slot early.
    assign push = (state_q == IDLE) && bus.req && !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.req) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    pdt_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (bus.out_ready),
        .din_i   (bus.data_in),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ack       = ack_q;
    assign bus.data_out  = fifo_dout;
    assign bus.out_valid = !fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.full      = fifo_full;

endmodule

// File: tb/tb_parallel_data_receiver.sv
// Directed test-plan scenarios followed by randomized traffic, checked against a queue model.
module tb_parallel_data_receiver;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    parallel_data_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) tif ();

    parallel_data_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored words in arrival order, and whether the current req pulse was taken.
    logic [WIDTH-1:0] mq[$];
    bit               m_taken = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit accept;
        bit take;
        if (rst) begin
            mq.delete();
            m_taken = 1'b0;
        end else begin
            accept = tif.req && !m_taken && (mq.size() < DEPTH);
            take   = tif.out_ready && (mq.size() > 0);
            if (take)   void'(mq.pop_front());
            if (accept) mq.push_back(tif.data_in);
            m_taken = tif.req && (m_taken || accept);
        end
    endtask

    task automatic compare_model();
        logic [WIDTH-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("ack",       32'(tif.ack),       32'(m_taken));
        chk("out_valid", 32'(tif.out_valid), 32'(mq.size() != 0));
        chk("data_out",  32'(tif.data_out),  32'(head));
        chk("count",     32'(tif.count),     32'(mq.size()));
        chk("full",      32'(tif.full),      32'(mq.size() == DEPTH));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic handshake(input logic [WIDTH-1:0] d);
        bit got;
        tif.req     = 1'b1;
        tif.data_in = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = tif.ack;
        end
        if (!got) chk("hs_ack_timeout", 32'(got), 32'd1);
        tif.req = 1'b0;
        got = 1'b1;
        for (int i = 0; i < 20 && got; i++) begin
            cycle();
            got = tif.ack;
        end
        if (got) chk("hs_release_timeout", 32'(got), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] drain_exp [4];

        rst           = 1'b1;
        tif.req       = 1'b0;
        tif.data_in   = '0;
        tif.out_ready = 1'b0;

        // Reset then idle
        cycle();
        cycle();
        chk("rst_ack",   32'(tif.ack),       32'd0);
        chk("rst_valid", 32'(tif.out_valid), 32'd0);
        chk("rst_dout",  32'(tif.data_out),  32'd0);
        chk("rst_count", 32'(tif.count),     32'd0);
        chk("rst_full",  32'(tif.full),      32'd0);
        rst = 1'b0;
        cycle();

        // Single transfer, req held three cycles
        tif.req     = 1'b1;
        tif.data_in = 4'h5;
        cycle();
        chk("single_ack",   32'(tif.ack),       32'd1);
        chk("single_dout",  32'(tif.data_out),  32'h5);
        chk("single_valid", 32'(tif.out_valid), 32'd1);
        cycle();
        cycle();
        chk("single_count", 32'(tif.count),     32'd1);
        tif.req = 1'b0;
        cycle();
        chk("single_ack_low", 32'(tif.ack),     32'd0);
        tif.out_ready = 1'b1;
        cycle();
        chk("single_drained", 32'(tif.count),   32'd0);
        tif.out_ready = 1'b0;

        // Fill to full, then a stalled fifth request
        handshake(4'h1);
        handshake(4'h2);
        handshake(4'h3);
        handshake(4'h4);
        chk("fill_full",  32'(tif.full),  32'd1);
        chk("fill_count", 32'(tif.count), 32'd4);
        tif.req     = 1'b1;
        tif.data_in = 4'h7;
        cycle();
        cycle();
        cycle();
        chk("stall_ack", 32'(tif.ack), 32'd0);
        tif.out_ready = 1'b1;
        cycle();
        chk("pop_no_push_count", 32'(tif.count), 32'd3);
        chk("pop_no_push_ack",   32'(tif.ack),   32'd0);
        tif.out_ready = 1'b0;
        cycle();
        chk("stalled_capture_ack",   32'(tif.ack),   32'd1);
        chk("stalled_capture_count", 32'(tif.count), 32'd4);
        tif.req = 1'b0;
        cycle();

        // Drain order across pointer wrap
        drain_exp[0] = 4'h2;
        drain_exp[1] = 4'h3;
        drain_exp[2] = 4'h4;
        drain_exp[3] = 4'h7;
        tif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(tif.data_out), 32'(drain_exp[i]));
            cycle();
        end
        chk("drain_valid", 32'(tif.out_valid), 32'd0);
        chk("drain_dout",  32'(tif.data_out),  32'd0);
        tif.out_ready = 1'b0;

        // Simultaneous push and pop at count 2
        handshake(4'h8);
        handshake(4'h9);
        chk("sim_pre_count", 32'(tif.count), 32'd2);
        tif.req       = 1'b1;
        tif.data_in   = 4'hA;
        tif.out_ready = 1'b1;
        cycle();
        chk("sim_count", 32'(tif.count),    32'd2);
        chk("sim_ack",   32'(tif.ack),      32'd1);
        chk("sim_head",  32'(tif.data_out), 32'h9);
        tif.req = 1'b0;
        cycle();
        chk("sim_next", 32'(tif.data_out), 32'hA);
        cycle();
        chk("sim_empty", 32'(tif.out_valid), 32'd0);
        tif.out_ready = 1'b0;

        // Reset in the middle of a handshake, req kept high
        tif.req     = 1'b1;
        tif.data_in = 4'h3;
        cycle();
        chk("mid_pre_ack",   32'(tif.ack),   32'd1);
        chk("mid_pre_count", 32'(tif.count), 32'd1);
        rst = 1'b1;
        cycle();
        chk("mid_rst_ack",   32'(tif.ack),   32'd0);
        chk("mid_rst_count", 32'(tif.count), 32'd0);
        rst = 1'b0;
        cycle();
        chk("mid_recap_ack",   32'(tif.ack),      32'd1);
        chk("mid_recap_count", 32'(tif.count),    32'd1);
        chk("mid_recap_dout",  32'(tif.data_out), 32'h3);
        tif.req = 1'b0;
        cycle();

        // Randomized traffic honouring the four-phase protocol
        for (int i = 0; i < 3000; i++) begin
            if (tif.req && tif.ack) begin
                if ($urandom_range(0, 3) == 0) tif.req = 1'b0;
            end else if (!tif.req && !tif.ack) begin
                if ($urandom_range(0, 2) == 0) begin
                    tif.req     = 1'b1;
                    tif.data_in = WIDTH'($urandom);
                end
            end
            tif.out_ready = ($urandom_range(0, 99) < 40);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parallel_data_receiver.md
# parallel_data_receiver

Receiving end of the 4-bit parallel data transfer path. Accepts words from an upstream transmitter over a four-phase req/ack handshake and buffers them in a small synchronous FIFO. Presents them to a downstream consumer through a first-word-fall-through valid/ready port. Sits after the transmitter's output register stage and decouples transmitter pacing from consumer pacing.

## Interface
- WIDTH, 4, data word width in bits
- DEPTH, 4, FIFO depth in words; power of two, at least 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  transmitter request; data_in valid while high
- data_in  input  WIDTH  word from transmitter; stable while req is high
- ack  output  1  registered acknowledge to transmitter
- data_out  output  WIDTH  head of FIFO; 0 when empty
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts data_out this cycle
- count  output  $clog2(DEPTH)+1  words currently stored
- full  output  1  count == DEPTH

## Operation
- Reset values (rst high at an edge): state IDLE, ack 0, rd/wr pointers 0, count 0, full 0, out_valid 0, data_out 0. FIFO memory contents are not reset.
- Handshake FSM, two states, ack is high exactly in ACK.
  - IDLE: on req=1 and full=0, write data_in into the FIFO and go to ACK.
  - IDLE: on req=1 and full=1, stay in IDLE with ack held 0. The transmitter stalls.
  - IDLE: on req=0, stay in IDLE.
  - ACK: on req=0, go to IDLE. On req=1, stay in ACK; no further write.
  - One write per req pulse, no matter how long req stays high.
- Output side: out_valid = (count != 0). A pop occurs when out_valid and out_ready are both high at an edge. Pop advances rd_ptr.
- Simultaneous push and pop: both take effect and count is unchanged.
- Push decision uses the registered full. When full, a pop in the same cycle does not allow a push in that cycle; the push occurs on the next edge if req is still high.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is one bit wider so full and empty can be told apart.
- out_ready while empty is ignored; no underflow. Overflow cannot occur because pushes are gated by full.
- Reset mid-handshake: FSM returns to IDLE with ack 0. If req is still high after reset, it is treated as a new request and that word is captured again.

## Timing
- Word capture is at the edge where state is IDLE, req=1 and full=0.
- ack is 1 after that capture edge. ack returns to 0 at the first edge that samples req=0.
- Write-to-output latency is one cycle. If the FIFO was empty, data_out and out_valid reflect the word immediately after the capture edge.
- data_out, out_valid, count and full are derived from registered state only; there is no combinational path from req or out_ready.
- Minimum full handshake is 4 cycles:
  - req high
  - capture edge, ack high
  - req low
  - ack low edge
- The transmitter must not raise req again until it sees ack=0.

## Structure
- Package pdt_pkg:
  - FSM state enum {IDLE, ACK}
  - default WIDTH = 4 and DEPTH = 4 constants
  - function for the pointer-width calculation
- Sub-module pdt_fifo: synchronous FWFT FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty.
  - Zero output when empty.
- The top level holds only the handshake FSM, the ack register and the push/pop gating.

## Test plan
- Reset then idle: rst high for 2 cycles, req=0.
  - Required: ack=0, out_valid=0, data_out=0, count=0, full=0.
- Single transfer:
  - Stimulus: data_in=4'h5 with req high; hold req 3 cycles, then drop it.
  - Required: one capture; ack high from capture until one edge after req falls; data_out=5 and out_valid=1 one cycle after capture; count=1. With out_ready=1, count returns to 0.
- Fill to full: out_ready=0; four handshakes with data 1, 2, 3, 4, then a fifth request with data 7.
  - Required: full=1 and count=4; fifth req gets no ack.
  - Then out_ready=1 for one cycle: data_out 1 is popped, and the stalled word 7 is captured on the following edge.
- Drain order: after the previous scenario, hold out_ready=1.
  - Required: data_out sequence 2, 3, 4, 7, then out_valid=0 and data_out=0; pointers wrap correctly.
- Simultaneous push/pop: count=2, a capture edge coinciding with a pop.
  - Required: count stays 2; FIFO order preserved.
- Reset mid-handshake: assert rst while in ACK with req=1 and count=1, then deassert rst with req still high.
  - Required: ack=0 and count=0 right after reset; the word is recaptured on the next edge and ack returns high.
